// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic SEL_SEQ = 1'b0;
    localparam logic SEL_BR  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_UPDATE,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Clearable wait counter; expired flags the last REQ cycle allowed before a fetch timeout.
module fetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_q;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Counter holds the number of unanswered REQ cycles already spent.
    assign expired_o = (count_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: imem handshake, one-deep branch redirect slot, halt and sticky timeout fault.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_offset,
    output logic            br_ready,
    input  logic            halt_req,
    output logic            pc_en,
    output logic            mux_control,
    output logic [XLEN-1:0] imm,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] retired_cnt
);

    fetch_state_t    state_q, state_d;
    logic            slot_full_q, slot_full_d;
    logic [XLEN-1:0] slot_off_q, slot_off_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic            br_ready_q, br_ready_d;
    logic            timer_expired;
    logic            capture;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != ST_REQ),
        .inc_i     ((state_q == ST_REQ) && !imem_ack),
        .expired_o (timer_expired)
    );

    assign capture = br_valid && br_ready_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        slot_full_d = slot_full_q;
        slot_off_d  = slot_off_q;
        retired_d   = retired_q;

        case (state_q)
            ST_IDLE:   state_d = halt_req ? ST_HALTED : ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    state_d = ST_UPDATE;
                end else if (timer_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_UPDATE: begin
                state_d     = halt_req ? ST_HALTED : ST_REQ;
                slot_full_d = 1'b0;
                retired_d   = retired_q + 1'b1;
            end
            ST_HALTED: if (!halt_req) state_d = ST_REQ;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase

        // A capture in the consuming cycle refills the slot for the following update.
        if (capture) begin
            slot_full_d = 1'b1;
            slot_off_d  = br_offset;
        end

        br_ready_d = !slot_full_d && (state_d != ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            slot_full_q <= 1'b0;
            slot_off_q  <= '0;
            retired_q   <= '0;
            br_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_full_q <= slot_full_d;
            slot_off_q  <= slot_off_d;
            retired_q   <= retired_d;
            br_ready_q  <= br_ready_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign pc_en       = (state_q == ST_UPDATE);
    assign mux_control = (pc_en && slot_full_q) ? SEL_BR : SEL_SEQ;
    assign imm         = (mux_control == SEL_BR) ? slot_off_q : '0;
    assign halted      = (state_q == ST_HALTED);
    assign fault       = (state_q == ST_FAULT);
    assign br_ready    = br_ready_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench: behavioural model compared every cycle, directed scenarios plus random traffic.
module tb_pc_fetch_ctrl;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 15;

    localparam int M_IDLE = 0, M_FETCH = 1, M_RETIRE = 2, M_HALT = 3, M_DEAD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req, imem_ack;
    logic            br_valid, br_ready;
    logic [XLEN-1:0] br_offset;
    logic            halt_req;
    logic            pc_en, mux_control, halted, fault;
    logic [XLEN-1:0] imm, retired_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode, REQ cycles spent, pending offsets, retire count.
    int              m_mode;
    int              m_spent;
    logic [XLEN-1:0] m_slot[$];
    logic [XLEN-1:0] m_retired;
    bit              m_fresh;

    pc_fetch_ctrl #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .br_valid    (br_valid),
        .br_offset   (br_offset),
        .br_ready    (br_ready),
        .halt_req    (halt_req),
        .pc_en       (pc_en),
        .mux_control (mux_control),
        .imm         (imm),
        .halted      (halted),
        .fault       (fault),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_br_ready();
        return !m_fresh && (m_slot.size() == 0) && (m_mode != M_DEAD);
    endfunction

    task automatic compare_model();
        logic            e_mux;
        logic [XLEN-1:0] e_imm;
        e_mux = (m_mode == M_RETIRE) && (m_slot.size() != 0);
        e_imm = e_mux ? m_slot[0] : '0;
        check("imem_req",    imem_req,    (m_mode == M_FETCH));
        check("pc_en",       pc_en,       (m_mode == M_RETIRE));
        check("mux_control", mux_control, e_mux);
        check("imm",         imm,         e_imm);
        check("halted",      halted,      (m_mode == M_HALT));
        check("fault",       fault,       (m_mode == M_DEAD));
        check("br_ready",    br_ready,    exp_br_ready());
        check("retired_cnt", retired_cnt, m_retired);
    endtask

    task automatic model_step(input bit rst_n, input bit ack, input bit bv,
                              input logic [XLEN-1:0] off, input bit halt);
        bit take;
        int next_mode;
        if (!rst_n) begin
            m_mode = M_IDLE; m_spent = 0; m_slot.delete(); m_retired = '0; m_fresh = 1'b1;
            return;
        end
        take      = bv && exp_br_ready();
        next_mode = m_mode;
        case (m_mode)
            M_IDLE:   next_mode = halt ? M_HALT : M_FETCH;
            M_FETCH: begin
                m_spent++;
                if (ack)                      next_mode = M_RETIRE;
                else if (m_spent >= MAX_WAIT) next_mode = M_DEAD;
            end
            M_RETIRE: begin
                m_retired++;
                if (m_slot.size() != 0) void'(m_slot.pop_front());
                next_mode = halt ? M_HALT : M_FETCH;
            end
            M_HALT:   if (!halt) next_mode = M_FETCH;
            default:  next_mode = M_DEAD;
        endcase
        if (take) m_slot.push_back(off);
        if (next_mode == M_FETCH && m_mode != M_FETCH) m_spent = 0;
        m_mode  = next_mode;
        m_fresh = 1'b0;
    endtask

    // Drive inputs for the current cycle, advance the model, then compare in the next cycle.
    task automatic tick(input bit rst_n, input bit ack, input bit bv,
                        input logic [XLEN-1:0] off, input bit halt);
        reset = rst_n; imem_ack = ack; br_valid = bv; br_offset = off; halt_req = halt;
        model_step(rst_n, ack, bv, off, halt);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [XLEN-1:0] neg8;
        bit stall;
        int stall_left;
        neg8 = -32'sd8;

        // Reset state, then zero-wait fetches: pc_en at cycles 2, 4, 6.
        do_reset();
        check("rst_br_ready", br_ready, 1'b0);
        check("rst_retired",  retired_cnt, 32'd0);
        tick(1, 1, 0, '0, 0);                    // -> cycle 1
        check("c1_req", imem_req, 1'b1);
        tick(1, 1, 0, '0, 0);                    // -> cycle 2
        check("c2_pc_en", pc_en, 1'b1);
        for (int c = 3; c <= 7; c++) tick(1, 1, 0, '0, 0);
        check("retired_3", retired_cnt, 32'd3);

        // Offset 5 captured at cycle 1 drives the update at cycle 2.
        do_reset();
        tick(1, 1, 0, '0, 0);
        check("br_ready_c1", br_ready, 1'b1);
        tick(1, 1, 1, 32'd5, 0);                 // -> cycle 2
        check("br5_imm", imm, 32'd5);
        check("br5_mux", mux_control, 1'b1);
        check("br5_ready_c2", br_ready, 1'b0);
        tick(1, 1, 0, '0, 0);
        check("br5_ready_c3", br_ready, 1'b1);
        tick(1, 1, 0, '0, 0);
        check("br5_c4_mux", mux_control, 1'b0);

        // Offset -8 offered while the held offset 12 is consumed.
        do_reset();
        tick(1, 0, 0, '0, 0);                    // -> cycle 1 (REQ)
        tick(1, 0, 1, 32'd12, 0);                // capture 12
        tick(1, 1, 0, '0, 0);                    // -> UPDATE
        check("hold12_imm", imm, 32'd12);
        check("hold12_ready", br_ready, 1'b0);
        tick(1, 1, 1, neg8, 0);
        tick(1, 1, 1, neg8, 0);
        check("neg8_imm", imm, 32'hFFFF_FFF8);

        // Timeout: 15 unanswered REQ cycles then sticky fault; reset recovers.
        do_reset();
        tick(1, 0, 0, '0, 0);
        for (int i = 1; i <= MAX_WAIT; i++) begin
            check("to_req_held", imem_req, 1'b1);
            tick(1, 0, 0, '0, 0);
        end
        check("to_fault", fault, 1'b1);
        check("to_ready", br_ready, 1'b0);
        tick(1, 1, 1, 32'd3, 0);
        tick(1, 1, 0, '0, 0);
        check("to_sticky", fault, 1'b1);
        tick(0, 0, 0, '0, 0);
        check("to_cleared", fault, 1'b0);

        // Ack in REQ cycle MAX_WAIT is accepted.
        do_reset();
        tick(1, 0, 0, '0, 0);
        for (int i = 1; i < MAX_WAIT; i++) tick(1, 0, 0, '0, 0);
        tick(1, 1, 0, '0, 0);
        check("late_ack_pc_en", pc_en, 1'b1);
        check("late_ack_fault", fault, 1'b0);

        // Halt together with ack; pending offset 20 survives the halt.
        do_reset();
        tick(1, 0, 0, '0, 0);
        tick(1, 1, 0, '0, 1);
        check("halt_pc_en", pc_en, 1'b1);
        tick(1, 0, 1, 32'd20, 1);
        check("halt_halted", halted, 1'b1);
        check("halt_no_req", imem_req, 1'b0);
        tick(1, 0, 0, '0, 1);
        tick(1, 0, 0, '0, 0);
        check("unhalt_req", imem_req, 1'b1);
        tick(1, 1, 0, '0, 0);
        check("halt20_imm", imm, 32'd20);

        // Randomized traffic with occasional stalls, halts and resets.
        do_reset();
        stall = 0; stall_left = 0;
        for (int n = 0; n < 4000; n++) begin
            bit r, a, b, h;
            if (!stall && $urandom_range(249) == 0) begin
                stall = 1; stall_left = MAX_WAIT + 3 - int'($urandom_range(4));
            end
            a = stall ? 1'b0 : ($urandom_range(3) != 0);
            if (stall && --stall_left == 0) stall = 0;
            b = ($urandom_range(2) == 0);
            h = ($urandom_range(9) == 0);
            r = !(($urandom_range(299) == 0) || (m_mode == M_DEAD && $urandom_range(15) == 0));
            tick(r, a, b, $urandom, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
